// File: rtl/psm_pwrup_scheduler.sv
// Power-up scheduler: grants up to MAX_ACTIVE domain ramps at a time, round-robin,
// with a minimum stagger between grants and a per-grant completion timeout.
module psm_pwrup_scheduler #(
    parameter  int NUM_DOM     = 4,
    parameter  int MAX_ACTIVE  = 2,
    parameter  int STAGGER_CYC = 8,
    parameter  int TIMEOUT_CYC = 1000,
    localparam int CNT_W       = $clog2(MAX_ACTIVE + 1),
    localparam int ID_W        = $clog2(NUM_DOM)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_DOM-1:0] req_i,
    input  logic [NUM_DOM-1:0] done_i,
    input  logic [NUM_DOM-1:0] fault_clr_i,
    output logic [NUM_DOM-1:0] gnt_o,
    output logic [CNT_W-1:0]   active_cnt_o,
    output logic [NUM_DOM-1:0] fault_o,
    output logic               fault_pulse_o,
    output logic [ID_W-1:0]    fault_id_o,
    output logic               busy_o
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    // The counter holds the cycles still blocked after a grant, so successive
    // grants rise STAGGER_CYC cycles apart (1 apart when STAGGER_CYC is 0).
    localparam int STG_LOAD = (STAGGER_CYC > 0) ? (STAGGER_CYC - 1) : 0;
    localparam int STG_W    = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;

    logic [NUM_DOM-1:0] gnt_r;
    logic [NUM_DOM-1:0] fault_r;
    logic [NUM_DOM-1:0] served_r;
    logic [CNT_W-1:0]   active_cnt_r;
    logic               fault_pulse_r;
    logic [ID_W-1:0]    fault_id_r;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [STG_W-1:0]   stagger_r;
    logic [TMR_W-1:0]   timer_r [NUM_DOM];

    logic [NUM_DOM-1:0] eligible_s;
    logic [NUM_DOM-1:0] done_rel_s;
    logic [NUM_DOM-1:0] abort_rel_s;
    logic [NUM_DOM-1:0] timeout_s;
    logic [NUM_DOM-1:0] release_s;
    logic [NUM_DOM-1:0] grant_vec_s;
    logic [NUM_DOM-1:0] gnt_next_s;
    logic [NUM_DOM-1:0] fault_next_s;
    logic [NUM_DOM-1:0] served_next_s;
    logic               found_s;
    logic               grant_en_s;
    logic [ID_W-1:0]    winner_s;
    logic [ID_W:0]      scan_sum_s;
    logic [ID_W-1:0]    scan_idx_s;
    logic [ID_W-1:0]    rr_ptr_next_s;
    logic [STG_W-1:0]   stagger_next_s;
    logic [ID_W-1:0]    timeout_id_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_DOM-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_DOM; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
        return cnt;
    endfunction

    assign eligible_s = req_i & ~gnt_r & ~fault_r & ~served_r;

    // Classify each outstanding grant: done beats abort beats timeout.
    always_comb begin
        done_rel_s  = {NUM_DOM{1'b0}};
        abort_rel_s = {NUM_DOM{1'b0}};
        timeout_s   = {NUM_DOM{1'b0}};
        for (int i = 0; i < NUM_DOM; i++) begin
            if (gnt_r[i]) begin
                if (done_i[i]) begin
                    done_rel_s[i] = 1'b1;
                end else if (!req_i[i]) begin
                    abort_rel_s[i] = 1'b1;
                end else if (timer_r[i] == TMR_W'(TIMEOUT_CYC - 1)) begin
                    timeout_s[i] = 1'b1;
                end else begin
                    timeout_s[i] = 1'b0;
                end
            end else begin
                done_rel_s[i] = 1'b0;
            end
        end
    end

    // Round-robin search for the first eligible domain at or above rr_ptr.
    always_comb begin
        found_s     = 1'b0;
        winner_s    = {ID_W{1'b0}};
        scan_sum_s  = {(ID_W + 1){1'b0}};
        scan_idx_s  = {ID_W{1'b0}};
        grant_vec_s = {NUM_DOM{1'b0}};
        for (int k = 0; k < NUM_DOM; k++) begin
            scan_sum_s = {1'b0, rr_ptr_r} + (ID_W + 1)'(k);
            if (scan_sum_s >= (ID_W + 1)'(NUM_DOM)) begin
                scan_sum_s = scan_sum_s - (ID_W + 1)'(NUM_DOM);
            end else begin
                scan_sum_s = scan_sum_s;
            end
            scan_idx_s = scan_sum_s[ID_W-1:0];
            if (!found_s && eligible_s[scan_idx_s]) begin
                found_s  = 1'b1;
                winner_s = scan_idx_s;
            end else begin
                found_s = found_s;
            end
        end
        grant_en_s = found_s && (active_cnt_r < CNT_W'(MAX_ACTIVE)) &&
                     (stagger_r == {STG_W{1'b0}});
        if (grant_en_s) begin
            grant_vec_s[winner_s] = 1'b1;
        end else begin
            grant_vec_s = {NUM_DOM{1'b0}};
        end
    end

    // Next-state for grants, faults, served bits, pointer and stagger counter.
    always_comb begin
        release_s    = done_rel_s | abort_rel_s | timeout_s;
        gnt_next_s   = (gnt_r & ~release_s) | grant_vec_s;
        fault_next_s = (fault_r & ~fault_clr_i) | timeout_s;
        timeout_id_s = {ID_W{1'b0}};
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (timeout_s[i]) begin
                timeout_id_s = ID_W'(i);
            end else begin
                timeout_id_s = timeout_id_s;
            end
        end
        served_next_s = served_r;
        for (int i = 0; i < NUM_DOM; i++) begin
            if (done_rel_s[i]) begin
                served_next_s[i] = 1'b1;
            end else if (!req_i[i]) begin
                served_next_s[i] = 1'b0;
            end else begin
                served_next_s[i] = served_r[i];
            end
        end
        if (winner_s == ID_W'(NUM_DOM - 1)) begin
            rr_ptr_next_s = {ID_W{1'b0}};
        end else begin
            rr_ptr_next_s = winner_s + ID_W'(1);
        end
        if (grant_en_s) begin
            stagger_next_s = STG_W'(STG_LOAD);
        end else if (stagger_r != {STG_W{1'b0}}) begin
            stagger_next_s = stagger_r - STG_W'(1);
        end else begin
            stagger_next_s = stagger_r;
        end
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r         <= {NUM_DOM{1'b0}};
            fault_r       <= {NUM_DOM{1'b0}};
            served_r      <= {NUM_DOM{1'b0}};
            active_cnt_r  <= {CNT_W{1'b0}};
            fault_pulse_r <= 1'b0;
            fault_id_r    <= {ID_W{1'b0}};
            rr_ptr_r      <= {ID_W{1'b0}};
            stagger_r     <= {STG_W{1'b0}};
        end else begin
            gnt_r         <= gnt_next_s;
            fault_r       <= fault_next_s;
            served_r      <= served_next_s;
            active_cnt_r  <= popcount(gnt_next_s);
            fault_pulse_r <= |timeout_s;
            fault_id_r    <= (|timeout_s) ? timeout_id_s : fault_id_r;
            rr_ptr_r      <= grant_en_s ? rr_ptr_next_s : rr_ptr_r;
            stagger_r     <= stagger_next_s;
        end
    end

    // Per-domain ramp timers: cleared on grant, count while granted, saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DOM; i++) begin
                timer_r[i] <= {TMR_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_DOM; i++) begin
                if (grant_vec_s[i]) begin
                    timer_r[i] <= {TMR_W{1'b0}};
                end else if (gnt_r[i] && (timer_r[i] != TMR_W'(TIMEOUT_CYC))) begin
                    timer_r[i] <= timer_r[i] + TMR_W'(1);
                end else begin
                    timer_r[i] <= timer_r[i];
                end
            end
        end
    end

    assign gnt_o         = gnt_r;
    assign active_cnt_o  = active_cnt_r;
    assign fault_o       = fault_r;
    assign fault_pulse_o = fault_pulse_r;
    assign fault_id_o    = fault_id_r;
    assign busy_o        = (|gnt_r) | (|eligible_s);

endmodule

// File: tb/tb_psm_pwrup_scheduler.sv
// Directed and randomized bench for psm_pwrup_scheduler with a cycle-level
// reference model built from the scheduling rules.
module tb_psm_pwrup_scheduler;

    localparam int N   = 4;
    localparam int MA  = 2;
    localparam int STG = 8;
    localparam int TO  = 1000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] clr = '0;
    logic [N-1:0] gnt;
    logic [1:0]   active_cnt;
    logic [N-1:0] fault;
    logic         pulse;
    logic [1:0]   fault_id;
    logic         busy;

    int checks = 0;
    int failures = 0;

    bit m_gnt[N];
    bit m_fault[N];
    bit m_served[N];
    int m_age[N];
    int m_ptr;
    int m_stag;
    bit m_pulse;
    int m_id;

    psm_pwrup_scheduler #(
        .NUM_DOM(N), .MAX_ACTIVE(MA), .STAGGER_CYC(STG), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done), .fault_clr_i(clr),
        .gnt_o(gnt), .active_cnt_o(active_cnt), .fault_o(fault),
        .fault_pulse_o(pulse), .fault_id_o(fault_id), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] m_gnt_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_gnt[i];
        return v;
    endfunction

    function automatic logic [N-1:0] m_fault_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_fault[i];
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_gnt[i]);
        return c;
    endfunction

    function automatic bit m_busy();
        bit b = 1'b0;
        for (int i = 0; i < N; i++)
            if (m_gnt[i] || (req[i] && !m_fault[i] && !m_served[i])) b = 1'b1;
        return b;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_gnt[i] = 1'b0; m_fault[i] = 1'b0; m_served[i] = 1'b0; m_age[i] = 0;
        end
        m_ptr = 0; m_stag = 0; m_pulse = 1'b0; m_id = 0;
    endfunction

    // One clock edge of the scheduling rules, from pre-edge state and inputs.
    function automatic void model_step();
        bit nx_gnt[N];
        bit nx_fault[N];
        bit nx_served[N];
        bit tmo[N];
        int winner = -1;
        int act = m_count();
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (winner < 0 && req[j] && !m_gnt[j] && !m_fault[j] && !m_served[j]) winner = j;
        end
        m_pulse = 1'b0;
        for (int i = 0; i < N; i++) begin
            nx_gnt[i] = m_gnt[i];
            nx_served[i] = req[i] ? m_served[i] : 1'b0;
            tmo[i] = 1'b0;
            if (m_gnt[i]) begin
                if (done[i]) begin
                    nx_gnt[i] = 1'b0; nx_served[i] = 1'b1;
                end else if (!req[i]) begin
                    nx_gnt[i] = 1'b0;
                end else if (m_age[i] == TO - 1) begin
                    nx_gnt[i] = 1'b0; tmo[i] = 1'b1;
                end else begin
                    m_age[i]++;
                end
            end
            nx_fault[i] = tmo[i] ? 1'b1 : (clr[i] ? 1'b0 : m_fault[i]);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (tmo[i]) begin
                m_pulse = 1'b1; m_id = i;
            end
        end
        if (act < MA && m_stag == 0 && winner >= 0) begin
            nx_gnt[winner] = 1'b1;
            m_age[winner] = 0;
            m_ptr = (winner + 1) % N;
            m_stag = (STG > 0) ? STG - 1 : 0;
        end else if (m_stag > 0) begin
            m_stag--;
        end
        for (int i = 0; i < N; i++) begin
            m_gnt[i] = nx_gnt[i]; m_fault[i] = nx_fault[i]; m_served[i] = nx_served[i];
        end
    endfunction

    task automatic compare_all();
        chk("gnt", 32'(gnt), 32'(m_gnt_vec()));
        chk("active_cnt", 32'(active_cnt), 32'(m_count()));
        chk("fault", 32'(fault), 32'(m_fault_vec()));
        chk("fault_pulse", 32'(pulse), 32'(m_pulse));
        chk("busy", 32'(busy), 32'(m_busy()));
        if (m_pulse) chk("fault_id", 32'(fault_id), 32'(m_id));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'd0);
        chk("async_rst_active", 32'(active_cnt), 32'd0);
        chk("async_rst_fault", 32'(fault), 32'd0);
        model_reset();
        step();
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] sel;
        int idx;
        int w;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_active", 32'(active_cnt), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_pulse", 32'(pulse), 32'd0);
        chk("rst_fault_id", 32'(fault_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Single request
        req = 4'b0001;
        step();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_active", 32'(active_cnt), 32'd1);
        repeat (19) step();
        done = 4'b0001;
        step();
        chk("single_release", 32'(gnt), 32'h0);
        chk("single_active0", 32'(active_cnt), 32'd0);
        done = '0; req = '0;
        repeat (12) step();

        // Concurrency cap and stagger from a fresh pointer
        async_reset();
        req = 4'b1111;
        step();
        chk("cap_gnt0", 32'(gnt), 32'h1);
        repeat (7) step();
        chk("cap_stagger_hold", 32'(gnt), 32'h1);
        step();
        chk("cap_gnt1", 32'(gnt), 32'h3);
        repeat (20) step();
        chk("cap_withheld", 32'(gnt), 32'h3);
        chk("cap_active2", 32'(active_cnt), 32'd2);
        done = 4'b0001;
        step();
        done = '0;
        chk("cap_release0", 32'(gnt), 32'h2);
        step();
        chk("cap_gnt2", 32'(gnt), 32'h6);

        // Reset mid-ramp, then arbitration restarts at index 0
        async_reset();
        step();
        chk("rst_restart0", 32'(gnt), 32'h1);
        repeat (8) step();
        chk("rst_gnt0011", 32'(gnt), 32'h3);
        async_reset();
        step();
        chk("rst_restart_again", 32'(gnt), 32'h1);

        // Round-robin fairness with request/done/drop cycling
        for (int n = 0; n < 8; n++) begin
            w = 0;
            while (gnt == '0 && w < 40) begin
                step();
                w++;
            end
            chk("rr_wait_bound", 32'(gnt != '0), 32'd1);
            idx = 0;
            for (int i = N - 1; i >= 0; i--) if (gnt[i]) idx = i;
            chk("rr_order", 32'(idx), 32'(n % N));
            sel = '0;
            sel[idx] = 1'b1;
            done = sel; req = req & ~sel;
            step();
            done = '0;
            step();
            req = req | sel;
        end
        req = '0;
        repeat (12) step();

        // Abort and re-request
        req = 4'b0010;
        step();
        chk("abort_gnt", 32'(gnt), 32'h2);
        repeat (2) step();
        req = '0;
        step();
        chk("abort_release", 32'(gnt), 32'h0);
        chk("abort_nofault", 32'(fault), 32'h0);
        req = 4'b0010;
        repeat (4) step();
        chk("abort_stagger_hold", 32'(gnt), 32'h0);
        step();
        chk("abort_regrant", 32'(gnt), 32'h2);
        req = '0;
        repeat (12) step();

        // Timeout, sticky fault, clear and re-grant
        req = 4'b0100;
        step();
        chk("to_gnt", 32'(gnt), 32'h4);
        for (int k = 1; k < TO; k++) step();
        chk("to_still_high", 32'(gnt), 32'h4);
        step();
        chk("to_release", 32'(gnt), 32'h0);
        chk("to_fault", 32'(fault), 32'h4);
        chk("to_pulse", 32'(pulse), 32'd1);
        chk("to_id", 32'(fault_id), 32'd2);
        step();
        chk("to_pulse_once", 32'(pulse), 32'd0);
        repeat (20) step();
        chk("to_blocked", 32'(gnt), 32'h0);
        clr = 4'b0100;
        step();
        clr = '0;
        chk("to_clr", 32'(fault), 32'h0);
        step();
        chk("to_regrant", 32'(gnt), 32'h4);
        done = 4'b0100;
        step();
        done = '0; req = '0;
        repeat (12) step();

        // Randomized traffic; domain 3 never completes so it times out repeatedly
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N - 1; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
                done[i] = (m_gnt[i] && $urandom_range(3) == 0) || ($urandom_range(15) == 0);
            end
            req[N-1] = 1'b1;
            done[N-1] = !m_gnt[N-1] && ($urandom_range(15) == 0);
            for (int i = 0; i < N; i++) clr[i] = ($urandom_range(127) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
